multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Main sequencing FSM for the multicycle RISC-V core. It decodes the latched instruction fields and drives the datapath strobes and mux selects one state per cycle: fetch, decode, address/execute, memory and writeback. It waits on a memory-ready handshake and counts retired instructions. It replaces the single-cycle `control_path` when the core shares one memory port between instruction and data.

## Interface
- `RETIRE_W`, default 32: width of the retired-instruction counter.

- `clk`  in  1  rising-edge clock
- `srst`  in  1  asynchronous, active-high reset
- `op_code`  in  7  instruction bits [6:0] from the instruction register
- `funct3`  in  3  instruction bits [14:12]
- `funct7_5`  in  1  instruction bit 30
- `zero`  in  1  ALU zero flag
- `mem_ready`  in  1  memory access complete this cycle
- `mem_req`  out  1  memory access request
- `mem_w`  out  1  memory write enable, qualified by `mem_req`
- `adr_src`  out  1  memory address select: 0 = PC, 1 = result
- `ir_write`  out  1  instruction register load
- `pc_write`  out  1  PC load
- `reg_w`  out  1  register file write
- `result_src`  out  2  result select: 00 = ALUOut, 01 = read data, 10 = ALU result
- `alu_src_a`  out  2  ALU A select: 00 = PC, 01 = old PC, 10 = rs1
- `alu_src_b`  out  2  ALU B select: 00 = rs2, 01 = immediate, 10 = constant 4
- `imm_src`  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J
- `alu_control`  out  3  000 = add, 001 = sub, 010 = and, 011 = or, 101 = slt
- `retired`  out  RETIRE_W  count of completed instructions
- `illegal`  out  1  sticky illegal-instruction flag (see Configuration)

## Operation
- Only the state register and the counter are sequential. Outputs are decoded combinationally from the state, plus `mem_ready` and `zero` where noted.
- Any output not listed for a state is 0.
- Supported opcodes:
  - lw 0000011
  - sw 0100011
  - R-type 0110011
  - I-ALU 0010011
  - beq 1100011
  - jal 1101111
- FETCH: `mem_req=1`, `adr_src=0`.
  - If `mem_ready=1`: also `ir_write=1`, `pc_write=1`, A=00, B=10, add, `result_src=10`; go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: A=01, B=01, `imm_src=10`, add (computes the branch target). Next state:
  - lw or sw: MEMADR
  - R-type: EXECR
  - I-ALU: EXECI
  - beq: BEQ
  - jal: JAL
  - any other opcode: ILLEGAL
- MEMADR: A=10, B=01, add. `imm_src` is 00 for lw and 01 for sw. Go to MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: `mem_req=1`, `adr_src=1`, `result_src=00`. Stay until `mem_ready`, then go to MEMWB.
- MEMWB: `result_src=01`, `reg_w=1`; go to FETCH.
- MEMWRITE: `mem_req=1`, `mem_w=1`, `adr_src=1`, `result_src=00`. Stay until `mem_ready`, then go to FETCH.
- EXECR: A=10, B=00, ALU op from the decoder below; go to ALUWB.
- EXECI: A=10, B=01, `imm_src=00`, ALU op from the decoder below; go to ALUWB.
- ALUWB: `result_src=00`, `reg_w=1`; go to FETCH.
- BEQ: A=10, B=00, sub, `result_src=00`, `pc_write=zero`; go to FETCH.
- JAL: A=01, B=10, add, `result_src=00`, `imm_src=11`, `pc_write=1`; go to ALUWB.
- ALU decoder, by `funct3`:
  - 000: sub when R-type and `funct7_5=1`, otherwise add
  - 010: slt
  - 110: or
  - 111: and
  - any other value: routes the instruction to ILLEGAL instead of EXECR/EXECI
- `retired` increments by 1 on every transition into FETCH from MEMWB, MEMWRITE, ALUWB or BEQ. It wraps modulo 2^RETIRE_W.

## Timing
- While `srst` is asserted:
  - state = FETCH and `retired` = 0
  - `illegal` = 0
  - every strobe (`mem_req`, `mem_w`, `ir_write`, `pc_write`, `reg_w`) is forced to 0 and every select is 0
- The first `mem_req` is driven in the cycle after `srst` is released.
- Reset asserted mid-instruction aborts at once. No partial writeback occurs, because `reg_w` is gated by reset.
- Cycle counts with zero wait states:
  - lw: 5 cycles
  - sw, R-type, I-ALU, jal: 4 cycles
  - beq: 3 cycles
- Each wait state adds 1 cycle. `mem_req` and `adr_src` hold steady while waiting.
- `mem_ready` is ignored outside FETCH, MEMREAD and MEMWRITE.
- A `mem_ready` arriving in the same cycle that `mem_req` rises completes that access.

## Configuration
- Macro: `MC_CTRL_ILLEGAL_TRAP_EN`.
- Defined:
  - ILLEGAL is terminal. All strobes are 0 and `illegal=1`.
  - The FSM stays in ILLEGAL until reset.
  - `retired` does not count the trapping instruction.
- Undefined:
  - ILLEGAL behaves as a 1-cycle NOP: go to FETCH with no strobes, no increment of `retired`.
  - `illegal` is tied to 0.

## Test plan
- Reset, then `mem_ready` held at 1: FETCH cycle has `mem_req=1`, `ir_write=1`, `pc_write=1`, A=00, B=10, `alu_control=000`.
- Execute `add` (0110011, f3=000, f7_5=0), then `sub` (f7_5=1): EXECR drives `alu_control` 000 then 001; ALUWB has `reg_w=1`; `retired` = 2.
- lw with `mem_ready` low for 3 cycles in MEMREAD: lw takes 8 cycles, `adr_src=1` throughout MEMREAD, MEMWB has `result_src=01` and `reg_w=1`.
- beq with `zero=0`, then with `zero=1`: `pc_write` is 0, then 1, in the BEQ cycle; each beq takes 3 cycles.
- Opcode 1110011 with the macro defined: the FSM stays in ILLEGAL and `illegal=1` until `srst`. Without the macro: the FSM returns to FETCH after 1 cycle with `retired` unchanged.
- `srst` asserted during MEMWRITE with `RETIRE_W=2` and `retired=3`: `mem_w` drops to 0 in that cycle, state becomes FETCH, `retired` becomes 0. A separate run of 4 completions wraps `retired` 3→0.

Source files
------------

// File: rtl/multicycle_controller.sv
// Main sequencing FSM of the multicycle RISC-V core (shared instruction/data memory port).
// Optional feature macro MC_CTRL_ILLEGAL_TRAP_EN: when defined, ILLEGAL is a terminal trap state.
module multicycle_controller #(
  parameter int RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                srst,
  input  logic [6:0]          op_code,
  input  logic [2:0]          funct3,
  input  logic                funct7_5,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                mem_w,
  output logic                adr_src,
  output logic                ir_write,
  output logic                pc_write,
  output logic                reg_w,
  output logic [1:0]          result_src,
  output logic [1:0]          alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          imm_src,
  output logic [2:0]          alu_control,
  output logic [RETIRE_W-1:0] retired,
  output logic                illegal
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_ILLEGAL  = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [RETIRE_W-1:0] RETIRE_ONE = RETIRE_W'(1);

  // Returns {legal, alu_op}; an unsupported funct3 makes the instruction illegal.
  function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic f7_5, input logic is_r);
    logic [3:0] res;
    case (f3)
      3'b000:  res = {1'b1, (is_r && f7_5) ? ALU_SUB : ALU_ADD};
      3'b010:  res = {1'b1, ALU_SLT};
      3'b110:  res = {1'b1, ALU_OR};
      3'b111:  res = {1'b1, ALU_AND};
      default: res = {1'b0, ALU_ADD};
    endcase
    return res;
  endfunction

  state_t     state;
  state_t     next_state;
  logic       alu_ok;
  logic [2:0] alu_op;
  logic       retire_inc;

  logic       mem_req_d, mem_w_d, adr_src_d, ir_write_d, pc_write_d, reg_w_d, illegal_d;
  logic [1:0] result_src_d, alu_src_a_d, alu_src_b_d, imm_src_d;
  logic [2:0] alu_control_d;

  assign {alu_ok, alu_op} = alu_decode(funct3, funct7_5, op_code == OP_R);

  // State register; reset aborts any instruction in flight.
  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      state <= S_FETCH;
    end else begin
      state <= next_state;
    end
  end

  // Retired-instruction counter, wraps naturally at its width.
  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      retired <= '0;
    end else if (retire_inc) begin
      retired <= retired + RETIRE_ONE;
    end else begin
      retired <= retired;
    end
  end

  // Next-state and ungated per-state control decode.
  always_comb begin
    next_state    = state;
    retire_inc    = 1'b0;
    mem_req_d     = 1'b0;
    mem_w_d       = 1'b0;
    adr_src_d     = 1'b0;
    ir_write_d    = 1'b0;
    pc_write_d    = 1'b0;
    reg_w_d       = 1'b0;
    illegal_d     = 1'b0;
    result_src_d  = 2'b00;
    alu_src_a_d   = 2'b00;
    alu_src_b_d   = 2'b00;
    imm_src_d     = 2'b00;
    alu_control_d = ALU_ADD;
    case (state)
      S_FETCH: begin
        mem_req_d = 1'b1;
        if (mem_ready) begin
          ir_write_d   = 1'b1;
          pc_write_d   = 1'b1;
          alu_src_b_d  = 2'b10;
          result_src_d = 2'b10;
          next_state   = S_DECODE;
        end else begin
          next_state = S_FETCH;
        end
      end
      S_DECODE: begin
        alu_src_a_d = 2'b01;
        alu_src_b_d = 2'b01;
        imm_src_d   = 2'b10;
        case (op_code)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_R:         next_state = alu_ok ? S_EXECR : S_ILLEGAL;
          OP_I:         next_state = alu_ok ? S_EXECI : S_ILLEGAL;
          OP_BEQ:       next_state = S_BEQ;
          OP_JAL:       next_state = S_JAL;
          default:      next_state = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        alu_src_a_d = 2'b10;
        alu_src_b_d = 2'b01;
        if (op_code == OP_LW) begin
          imm_src_d  = 2'b00;
          next_state = S_MEMREAD;
        end else begin
          imm_src_d  = 2'b01;
          next_state = S_MEMWRITE;
        end
      end
      S_MEMREAD: begin
        mem_req_d  = 1'b1;
        adr_src_d  = 1'b1;
        next_state = mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        result_src_d = 2'b01;
        reg_w_d      = 1'b1;
        retire_inc   = 1'b1;
        next_state   = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req_d  = 1'b1;
        mem_w_d    = 1'b1;
        adr_src_d  = 1'b1;
        retire_inc = mem_ready;
        next_state = mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECR: begin
        alu_src_a_d   = 2'b10;
        alu_control_d = alu_op;
        next_state    = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a_d   = 2'b10;
        alu_src_b_d   = 2'b01;
        alu_control_d = alu_op;
        next_state    = S_ALUWB;
      end
      S_ALUWB: begin
        reg_w_d    = 1'b1;
        retire_inc = 1'b1;
        next_state = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a_d   = 2'b10;
        alu_control_d = ALU_SUB;
        pc_write_d    = zero;
        retire_inc    = 1'b1;
        next_state    = S_FETCH;
      end
      S_JAL: begin
        alu_src_a_d = 2'b01;
        alu_src_b_d = 2'b10;
        imm_src_d   = 2'b11;
        pc_write_d  = 1'b1;
        next_state  = S_ALUWB;
      end
      S_ILLEGAL: begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        illegal_d  = 1'b1;
        next_state = S_ILLEGAL;
`else
        next_state = S_FETCH;
`endif
      end
      default: begin
        next_state = S_FETCH;
      end
    endcase
  end

  // Reset forces every strobe and select low immediately, so an aborted writeback never lands.
  always_comb begin
    if (srst) begin
      mem_req     = 1'b0;
      mem_w       = 1'b0;
      adr_src     = 1'b0;
      ir_write    = 1'b0;
      pc_write    = 1'b0;
      reg_w       = 1'b0;
      illegal     = 1'b0;
      result_src  = 2'b00;
      alu_src_a   = 2'b00;
      alu_src_b   = 2'b00;
      imm_src     = 2'b00;
      alu_control = 3'b000;
    end else begin
      mem_req     = mem_req_d;
      mem_w       = mem_w_d;
      adr_src     = adr_src_d;
      ir_write    = ir_write_d;
      pc_write    = pc_write_d;
      reg_w       = reg_w_d;
      illegal     = illegal_d;
      result_src  = result_src_d;
      alu_src_a   = alu_src_a_d;
      alu_src_b   = alu_src_b_d;
      imm_src     = imm_src_d;
      alu_control = alu_control_d;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Table-driven bench for multicycle_controller (RETIRE_W=2 so the counter wrap is reachable).
module tb_multicycle_controller;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BAD = 7'b1110011;

  logic       clk = 1'b0;
  logic       srst = 1'b1;
  logic [6:0] op_code = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       funct7_5 = 1'b0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_w, adr_src, ir_write, pc_write, reg_w, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;
  logic [1:0] retired;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       name;
    logic        rst;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic        z;
    logic        rdy;
    logic [16:0] ctl;
    logic [1:0]  ret;
    logic        ill;
  } vec_t;

  vec_t tbl[$];

  multicycle_controller #(.RETIRE_W(2)) dut (
    .clk(clk), .srst(srst), .op_code(op_code), .funct3(funct3), .funct7_5(funct7_5),
    .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_w(mem_w), .adr_src(adr_src),
    .ir_write(ir_write), .pc_write(pc_write), .reg_w(reg_w), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src),
    .alu_control(alu_control), .retired(retired), .illegal(illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] c(input logic mreq, input logic mw, input logic adr,
                                    input logic irw, input logic pcw, input logic rw,
                                    input logic [1:0] rs, input logic [1:0] a,
                                    input logic [1:0] b, input logic [1:0] imm,
                                    input logic [2:0] alu);
    return {mreq, mw, adr, irw, pcw, rw, rs, a, b, imm, alu};
  endfunction

  function automatic logic [16:0] ctl_now();
    return {mem_req, mem_w, adr_src, ir_write, pc_write, reg_w,
            result_src, alu_src_a, alu_src_b, imm_src, alu_control};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input string n, input logic rst, input logic [6:0] op, input logic [2:0] f3,
                     input logic f7, input logic z, input logic rdy, input logic [16:0] ctl,
                     input logic [1:0] ret, input logic ill);
    tbl.push_back('{n, rst, op, f3, f7, z, rdy, ctl, ret, ill});
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    srst = v.rst; op_code = v.op; funct3 = v.f3; funct7_5 = v.f7; zero = v.z; mem_ready = v.rdy;
    #1;
    check({v.name, "/ctl"}, {15'd0, ctl_now()}, {15'd0, v.ctl});
    check({v.name, "/retired"}, {30'd0, retired}, {30'd0, v.ret});
    check({v.name, "/illegal"}, {31'd0, illegal}, {31'd0, v.ill});
  endtask

  logic [16:0] k_idle, k_fetch, k_fwait, k_dec, k_aluwb, k_madr_lw, k_madr_sw;
  logic [16:0] k_mread, k_mwb, k_mwrite, k_beq0, k_beq1, k_jal;

  initial begin
    k_idle    = c(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
    k_fetch   = c(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000);
    k_fwait   = c(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
    k_dec     = c(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 2'b10, 3'b000);
    k_aluwb   = c(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
    k_madr_lw = c(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000);
    k_madr_sw = c(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b01, 3'b000);
    k_mread   = c(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
    k_mwb     = c(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000);
    k_mwrite  = c(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
    k_beq0    = c(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b00, 3'b001);
    k_beq1    = c(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b10, 2'b00, 2'b00, 3'b001);
    k_jal     = c(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b01, 2'b10, 2'b11, 3'b000);

    add("reset",      1'b1, OP_R,   3'b000, 1'b0, 1'b0, 1'b1, k_idle,  2'd0, 1'b0);
    add("add_fetch",  1'b0, OP_R,   3'b000, 1'b0, 1'b0, 1'b1, k_fetch, 2'd0, 1'b0);
    add("add_dec",    1'b0, OP_R,   3'b000, 1'b0, 1'b1, 1'b1, k_dec,   2'd0, 1'b0);
    add("add_exec",   1'b0, OP_R,   3'b000, 1'b0, 1'b0, 1'b1,
        c(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b00, 3'b000), 2'd0, 1'b0);
    add("add_wb",     1'b0, OP_R,   3'b000, 1'b0, 1'b0, 1'b1, k_aluwb, 2'd0, 1'b0);
    add("sub_fetch",  1'b0, OP_R,   3'b000, 1'b1, 1'b0, 1'b1, k_fetch, 2'd1, 1'b0);
    add("sub_dec",    1'b0, OP_R,   3'b000, 1'b1, 1'b0, 1'b1, k_dec,   2'd1, 1'b0);
    add("sub_exec",   1'b0, OP_R,   3'b000, 1'b1, 1'b0, 1'b1,
        c(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b00, 3'b001), 2'd1, 1'b0);
    add("sub_wb",     1'b0, OP_R,   3'b000, 1'b1, 1'b0, 1'b1, k_aluwb, 2'd1, 1'b0);
    add("lw_fetch",   1'b0, OP_LW,  3'b010, 1'b0, 1'b0, 1'b1, k_fetch, 2'd2, 1'b0);
    add("lw_dec",     1'b0, OP_LW,  3'b010, 1'b0, 1'b0, 1'b1, k_dec,   2'd2, 1'b0);
    add("lw_madr",    1'b0, OP_LW,  3'b010, 1'b0, 1'b0, 1'b1, k_madr_lw, 2'd2, 1'b0);
    add("lw_wait1",   1'b0, OP_LW,  3'b010, 1'b0, 1'b0, 1'b0, k_mread, 2'd2, 1'b0);
    add("lw_wait2",   1'b0, OP_LW,  3'b010, 1'b0, 1'b0, 1'b0, k_mread, 2'd2, 1'b0);
    add("lw_wait3",   1'b0, OP_LW,  3'b010, 1'b0, 1'b0, 1'b0, k_mread, 2'd2, 1'b0);
    add("lw_read",    1'b0, OP_LW,  3'b010, 1'b0, 1'b0, 1'b1, k_mread, 2'd2, 1'b0);
    add("lw_wb",      1'b0, OP_LW,  3'b010, 1'b0, 1'b0, 1'b1, k_mwb,   2'd2, 1'b0);
    add("beq0_fetch", 1'b0, OP_BEQ, 3'b000, 1'b0, 1'b0, 1'b1, k_fetch, 2'd3, 1'b0);
    add("beq0_dec",   1'b0, OP_BEQ, 3'b000, 1'b0, 1'b0, 1'b1, k_dec,   2'd3, 1'b0);
    add("beq0_br",    1'b0, OP_BEQ, 3'b000, 1'b0, 1'b0, 1'b1, k_beq0,  2'd3, 1'b0);
    add("beq1_fetch", 1'b0, OP_BEQ, 3'b000, 1'b0, 1'b1, 1'b1, k_fetch, 2'd0, 1'b0);
    add("beq1_dec",   1'b0, OP_BEQ, 3'b000, 1'b0, 1'b1, 1'b1, k_dec,   2'd0, 1'b0);
    add("beq1_br",    1'b0, OP_BEQ, 3'b000, 1'b0, 1'b1, 1'b1, k_beq1,  2'd0, 1'b0);
    add("ori_fetch",  1'b0, OP_I,   3'b110, 1'b0, 1'b0, 1'b1, k_fetch, 2'd1, 1'b0);
    add("ori_dec",    1'b0, OP_I,   3'b110, 1'b0, 1'b0, 1'b1, k_dec,   2'd1, 1'b0);
    add("ori_exec",   1'b0, OP_I,   3'b110, 1'b0, 1'b0, 1'b1,
        c(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b011), 2'd1, 1'b0);
    add("ori_wb",     1'b0, OP_I,   3'b110, 1'b0, 1'b0, 1'b1, k_aluwb, 2'd1, 1'b0);
    add("slti_fetch", 1'b0, OP_I,   3'b010, 1'b1, 1'b0, 1'b1, k_fetch, 2'd2, 1'b0);
    add("slti_dec",   1'b0, OP_I,   3'b010, 1'b1, 1'b0, 1'b1, k_dec,   2'd2, 1'b0);
    add("slti_exec",  1'b0, OP_I,   3'b010, 1'b1, 1'b0, 1'b1,
        c(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b101), 2'd2, 1'b0);
    add("slti_wb",    1'b0, OP_I,   3'b010, 1'b1, 1'b0, 1'b1, k_aluwb, 2'd2, 1'b0);
    add("and_fetch",  1'b0, OP_R,   3'b111, 1'b0, 1'b0, 1'b1, k_fetch, 2'd3, 1'b0);
    add("and_dec",    1'b0, OP_R,   3'b111, 1'b0, 1'b0, 1'b1, k_dec,   2'd3, 1'b0);
    add("and_exec",   1'b0, OP_R,   3'b111, 1'b0, 1'b0, 1'b1,
        c(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b00, 3'b010), 2'd3, 1'b0);
    add("and_wb",     1'b0, OP_R,   3'b111, 1'b0, 1'b0, 1'b1, k_aluwb, 2'd3, 1'b0);
    add("jal_fetch",  1'b0, OP_JAL, 3'b000, 1'b0, 1'b0, 1'b1, k_fetch, 2'd0, 1'b0);
    add("jal_dec",    1'b0, OP_JAL, 3'b000, 1'b0, 1'b0, 1'b1, k_dec,   2'd0, 1'b0);
    add("jal_jump",   1'b0, OP_JAL, 3'b000, 1'b0, 1'b0, 1'b1, k_jal,   2'd0, 1'b0);
    add("jal_wb",     1'b0, OP_JAL, 3'b000, 1'b0, 1'b0, 1'b1, k_aluwb, 2'd0, 1'b0);
    add("sw_fwait",   1'b0, OP_SW,  3'b010, 1'b0, 1'b0, 1'b0, k_fwait, 2'd1, 1'b0);
    add("sw_fetch",   1'b0, OP_SW,  3'b010, 1'b0, 1'b0, 1'b1, k_fetch, 2'd1, 1'b0);
    add("sw_dec",     1'b0, OP_SW,  3'b010, 1'b0, 1'b0, 1'b1, k_dec,   2'd1, 1'b0);
    add("sw_madr",    1'b0, OP_SW,  3'b010, 1'b0, 1'b0, 1'b1, k_madr_sw, 2'd1, 1'b0);
    add("sw_write",   1'b0, OP_SW,  3'b010, 1'b0, 1'b0, 1'b1, k_mwrite, 2'd1, 1'b0);
    add("add2_fetch", 1'b0, OP_R,   3'b000, 1'b0, 1'b0, 1'b1, k_fetch, 2'd2, 1'b0);
    add("add2_dec",   1'b0, OP_R,   3'b000, 1'b0, 1'b0, 1'b1, k_dec,   2'd2, 1'b0);
    add("add2_exec",  1'b0, OP_R,   3'b000, 1'b0, 1'b0, 1'b1,
        c(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b00, 3'b000), 2'd2, 1'b0);
    add("add2_wb",    1'b0, OP_R,   3'b000, 1'b0, 1'b0, 1'b1, k_aluwb, 2'd2, 1'b0);
    add("sw2_fetch",  1'b0, OP_SW,  3'b010, 1'b0, 1'b0, 1'b1, k_fetch, 2'd3, 1'b0);
    add("sw2_dec",    1'b0, OP_SW,  3'b010, 1'b0, 1'b0, 1'b1, k_dec,   2'd3, 1'b0);
    add("sw2_madr",   1'b0, OP_SW,  3'b010, 1'b0, 1'b0, 1'b1, k_madr_sw, 2'd3, 1'b0);
    add("sw2_wait",   1'b0, OP_SW,  3'b010, 1'b0, 1'b0, 1'b0, k_mwrite, 2'd3, 1'b0);

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i]);
    end

    // Reset lands in the middle of the MEMWRITE wait: strobes and counter clear at once.
    #1 srst = 1'b1;
    #1;
    check("abort/mem_w", {31'd0, mem_w}, 32'd0);
    check("abort/ctl", {15'd0, ctl_now()}, {15'd0, k_idle});
    check("abort/retired", {30'd0, retired}, 32'd0);
    apply('{"abort_hold", 1'b1, OP_BAD, 3'b000, 1'b0, 1'b0, 1'b1, k_idle, 2'd0, 1'b0});

    // Unsupported opcode, then an R-type with an unsupported funct3.
    apply('{"bad_fetch", 1'b0, OP_BAD, 3'b000, 1'b0, 1'b0, 1'b1, k_fetch, 2'd0, 1'b0});
    apply('{"bad_dec",   1'b0, OP_BAD, 3'b000, 1'b0, 1'b0, 1'b1, k_dec,   2'd0, 1'b0});
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    for (int i = 0; i < 4; i++) begin
      apply('{"bad_trap", 1'b0, OP_BAD, 3'b000, 1'b0, 1'b0, 1'b1, k_idle, 2'd0, 1'b1});
    end
    apply('{"trap_rst",   1'b1, OP_R, 3'b001, 1'b0, 1'b0, 1'b1, k_idle,  2'd0, 1'b0});
    apply('{"f3_fetch",   1'b0, OP_R, 3'b001, 1'b0, 1'b0, 1'b1, k_fetch, 2'd0, 1'b0});
    apply('{"f3_dec",     1'b0, OP_R, 3'b001, 1'b0, 1'b0, 1'b1, k_dec,   2'd0, 1'b0});
    apply('{"f3_trap",    1'b0, OP_R, 3'b001, 1'b0, 1'b0, 1'b1, k_idle,  2'd0, 1'b1});
    apply('{"f3_trap2",   1'b0, OP_R, 3'b001, 1'b0, 1'b0, 1'b1, k_idle,  2'd0, 1'b1});
    apply('{"f3_rst",     1'b1, OP_R, 3'b001, 1'b0, 1'b0, 1'b1, k_idle,  2'd0, 1'b0});
`else
    apply('{"bad_nop",    1'b0, OP_R, 3'b001, 1'b0, 1'b0, 1'b1, k_idle,  2'd0, 1'b0});
    apply('{"f3_fetch",   1'b0, OP_R, 3'b001, 1'b0, 1'b0, 1'b1, k_fetch, 2'd0, 1'b0});
    apply('{"f3_dec",     1'b0, OP_R, 3'b001, 1'b0, 1'b0, 1'b1, k_dec,   2'd0, 1'b0});
    apply('{"f3_nop",     1'b0, OP_R, 3'b001, 1'b0, 1'b0, 1'b1, k_idle,  2'd0, 1'b0});
    apply('{"f3_refetch", 1'b0, OP_R, 3'b000, 1'b0, 1'b0, 1'b1, k_fetch, 2'd0, 1'b0});
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
